// File: rtl/mips_fetch_pkg.sv
// Shared types and field positions for the instruction fetch stage.
package mips_fetch_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    ISSUE = 1'b1
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;
  localparam int JUMP_MSB  = 25;
  localparam int JUMP_LSB  = 0;

endpackage

// File: rtl/next_pc_mux.sv
// Priority selection of the next program counter: JR, then J/JAL, then
// taken branch, then sequential. With ALIGN_CHECK_EN defined, register and
// branch targets are checked for word alignment and the low bits dropped.
import mips_fetch_pkg::*;

module next_pc_mux #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]         pc_plus4,
  input  logic [JUMP_MSB:JUMP_LSB] jump_index,
  input  logic                     jump,
  input  logic                     jr,
  input  logic                     branch_taken,
  input  logic [WIDTH-1:0]         jr_target,
  input  logic [WIDTH-1:0]         branch_target,
  output logic [WIDTH-1:0]         next_pc,
  output logic                     misaligned
);

  logic [WIDTH-1:0] raw_pc;

  // Redirect priority; the jump form keeps the upper nibble of pc_plus4.
  always_comb begin
    raw_pc = pc_plus4;
    if (jr) begin
      raw_pc = jr_target;
    end else if (jump) begin
      raw_pc = {pc_plus4[WIDTH-1:28], jump_index, 2'b00};
    end else if (branch_taken) begin
      raw_pc = branch_target;
    end
  end

`ifdef ALIGN_CHECK_EN
  // Only externally supplied targets can be misaligned; the jump form never is.
  assign misaligned = (jr | (~jump & branch_taken)) & (|raw_pc[1:0]);
  assign next_pc    = {raw_pc[WIDTH-1:2], 2'b00};
`else
  assign misaligned = 1'b0;
  assign next_pc    = raw_pc;
`endif

endmodule

// File: rtl/instruction_fetch_unit.sv
// Single-issue fetch stage: owns the PC, fetches through a ready handshake,
// holds the instruction register and applies redirects on retire.
// Optional feature macro: ALIGN_CHECK_EN (sticky misaligned-target flag).
//
// state | meaning
// FETCH | request imem at pc, wait for imem_ready, capture instruction
// ISSUE | instruction live downstream; retire when stall is low
import mips_fetch_pkg::*;

module instruction_fetch_unit #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ready,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic             jr,
  input  logic [WIDTH-1:0] jr_target,
  output logic [WIDTH-1:0] instr,
  output logic [5:0]       op,
  output logic [5:0]       funct,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             instr_valid,
  output logic             addr_error
);

  fetch_state_t     state_q, state_d;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] instr_q;
  logic             instr_valid_q;
  logic             addr_error_q;
  logic             load_instr;
  logic             retire;
  logic [WIDTH-1:0] next_pc;
  logic             misaligned;

  assign pc_plus4 = pc_q + WIDTH'(4);

  next_pc_mux #(.WIDTH(WIDTH)) u_next_pc_mux (
    .pc_plus4      (pc_plus4),
    .jump_index    (instr_q[JUMP_MSB:JUMP_LSB]),
    .jump          (jump),
    .jr            (jr),
    .branch_taken  (branch_taken),
    .jr_target     (jr_target),
    .branch_target (branch_target),
    .next_pc       (next_pc),
    .misaligned    (misaligned)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake control; the request is masked during reset.
  always_comb begin
    state_d    = state_q;
    imem_req   = 1'b0;
    load_instr = 1'b0;
    retire     = 1'b0;
    case (state_q)
      FETCH: begin
        imem_req = ~reset;
        if (imem_ready) begin
          load_instr = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (!stall) begin
          retire  = 1'b1;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // Datapath registers: PC advances on retire, instruction captured on ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      addr_error_q  <= 1'b0;
    end else begin
      if (load_instr) begin
        instr_q       <= imem_rdata;
        instr_valid_q <= 1'b1;
      end
      if (retire) begin
        pc_q          <= next_pc;
        instr_valid_q <= 1'b0;
        if (misaligned) begin
          addr_error_q <= 1'b1;
        end
      end
    end
  end

  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign addr_error  = addr_error_q;
  assign op          = instr_q[OP_MSB:OP_LSB];
  assign funct       = instr_q[FUNCT_MSB:FUNCT_LSB];

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Single-issue instruction fetch stage that sits directly upstream of the control decoder. It owns the program counter, requests instructions from instruction memory through a ready handshake, holds the fetched word in an instruction register, and presents the opcode and function fields to the control unit. It also applies jump, jump-register and branch redirects when the current instruction retires.

## Interface
Parameters:
- RESET_PC, 32'h0040_0000: PC value loaded on reset.
- WIDTH, 32: address and instruction width.

Ports:
- clk  input  1  core clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- imem_req  output  1  instruction read request.
- imem_addr  output  WIDTH  read address (current PC).
- imem_ready  input  1  imem_rdata valid this cycle.
- imem_rdata  input  WIDTH  instruction word.
- stall  input  1  downstream not ready; hold current instruction.
- branch_taken  input  1  current instruction is a taken BEQ/BNE.
- branch_target  input  WIDTH  branch destination.
- jump  input  1  current instruction is J/JAL.
- jr  input  1  current instruction is JR.
- jr_target  input  WIDTH  register value for JR.
- instr  output  WIDTH  instruction register.
- op  output  6  instr[31:26], drives control OP.
- funct  output  6  instr[5:0], drives control Function.
- pc_plus4  output  WIDTH  PC of current instruction + 4 (JAL link, branch base).
- instr_valid  output  1  instr holds a live instruction.
- addr_error  output  1  sticky misaligned-target flag (see Configuration).

## Operation
- States: FETCH, ISSUE.
- FETCH: imem_req=1, imem_addr=pc. On imem_ready: instr<=imem_rdata, instr_valid<=1, go ISSUE. Without imem_ready: stay, address held stable.
- ISSUE: imem_req=0. If stall=1: hold everything. If stall=0: instruction retires; pc<=next_pc, instr_valid<=0, go FETCH.
- next_pc priority: jr -> jr_target; else jump -> {pc_plus4[31:28], instr[25:0], 2'b00}; else branch_taken -> branch_target; else pc_plus4.
- Redirect inputs sampled only in ISSUE with stall=0; ignored otherwise.
- imem_ready outside FETCH is ignored.
- pc_plus4 = pc + 4, modulo 2^WIDTH (0xFFFF_FFFC wraps to 0x0000_0000).
- op/funct are combinational slices of instr.

## Timing
- Reset (reset=1 at an edge): pc=RESET_PC, state=FETCH, instr=0, instr_valid=0, addr_error=0; pc_plus4=RESET_PC+4; imem_req forced 0 while reset is high.
- Reset mid-fetch or mid-issue: abandon the outstanding request. Any imem_ready in the reset cycle is discarded.
- Zero-wait memory: 2 cycles per instruction (FETCH with ready, ISSUE with stall=0). Each memory wait cycle adds 1 cycle; each stall cycle adds 1 cycle.
- instr_valid rises the edge after the FETCH cycle with imem_ready. It falls the edge after the ISSUE cycle with stall=0.
- Redirect takes effect on the next imem_addr; no wrong-path fetch occurs.

## Configuration
- ALIGN_CHECK_EN defined: a redirect target with bits[1:0]!=0 sets addr_error (sticky until reset). The PC is loaded with bits[1:0] forced to 0.
- Not defined: addr_error tied 0; targets loaded unmodified.

## Structure
- Package mips_fetch_pkg: state enum (FETCH, ISSUE), RESET_PC default, OP/FUNCT/JUMP field bit positions.
- One sub-module: next_pc_mux, the combinational priority selection of next_pc (and alignment masking when ALIGN_CHECK_EN).

## Test plan
- Reset, zero-wait memory returning 0x2008_0005 at 0x0040_0000 -> instr_valid high at cycle 2, op=0x08; next imem_addr=0x0040_0004.
- Memory ready delayed 3 cycles -> imem_addr stable at 0x0040_0000 for all 4 FETCH cycles; instr captured only on ready.
- stall held 5 cycles in ISSUE -> instr and pc unchanged, imem_req=0; release -> imem_addr=pc+4.
- jump with instr[25:0]=0x010_0008 at pc 0x0040_0010 -> next imem_addr=0x0040_0020. jr with jr_target=0x0040_0100 asserted together with jump and branch_taken -> next imem_addr=0x0040_0100.
- branch_taken with target 0x0040_0003 -> ALIGN_CHECK_EN: imem_addr=0x0040_0000, addr_error=1 sticky. Without the macro: imem_addr=0x0040_0003, addr_error=0.
- reset asserted during FETCH with imem_ready=1 -> instr stays 0, instr_valid=0; after reset, imem_addr=RESET_PC.
